// File: rtl/layer2_pkg.sv
// Shared constants and read-side state type for the layer_2 output serializer.
package layer2_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_OUT_CH = 64;
  localparam int unsigned CH_IDX_W   = $clog2(NUM_OUT_CH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;
endpackage

// File: rtl/layer2_vec_bank.sv
// One full-vector register bank: whole-vector write, async clear, channel-indexed read.
module layer2_vec_bank
  import layer2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_we,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [$clog2(NUM_CH)-1:0]    i_rd_idx,
  output logic [DATA_WIDTH-1:0]        o_rd_data
);

  logic [NUM_CH*DATA_WIDTH-1:0] r_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem <= i_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/layer2_out_serializer.sv
// Captures layer_2 output vectors into a ping-pong buffer and replays them one channel
// per beat on a valid/ready stream; vectors arriving with both banks busy are dropped and counted.
module layer2_out_serializer
  import layer2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_CH        = 64,
  parameter int unsigned VEC_PER_FRAME = 220,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(NUM_CH)-1:0]    m_ch_idx,
  output logic                         m_last,
  output logic                         m_last_frame,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned VC_W = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [VC_W-1:0] LAST_VEC = VC_W'(VEC_PER_FRAME - 1);

  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  rd_state_t             r_state;
  logic [CH_W-1:0]       r_ch;
  logic [VC_W-1:0]       r_vec_cnt;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_stream;
  logic                  w_hs;
  logic                  w_release;
  logic                  w_wr_busy;
  logic                  w_cap;
  logic                  w_drop;
  logic [1:0]            w_we;
  logic [1:0]            w_clr;
  logic [DATA_WIDTH-1:0] w_bank_data [2];

  assign w_stream  = (r_state == STREAM);
  assign w_hs      = w_stream && m_ready;
  assign w_release = w_hs && (r_ch == LAST_CH);
  // A bank freed by the read side on this edge may be refilled on the same edge.
  assign w_wr_busy = r_full[r_wr_bank] && !(w_release && (r_rd_bank == r_wr_bank));
  assign w_cap     = valid_in && !w_wr_busy;
  assign w_drop    = valid_in && w_wr_busy;
  assign w_we      = {w_cap && r_wr_bank, w_cap && !r_wr_bank};
  assign w_clr     = {w_release && r_rd_bank, w_release && !r_rd_bank};

  layer2_vec_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH)) u_bank_ping (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we[0]),
    .i_data    (data_in),
    .i_rd_idx  (r_ch),
    .o_rd_data (w_bank_data[0])
  );

  layer2_vec_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH)) u_bank_pong (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we[1]),
    .i_data    (data_in),
    .i_rd_idx  (r_ch),
    .o_rd_data (w_bank_data[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (w_we[b]) begin
          r_full[b] <= 1'b1;
        end else if (w_clr[b]) begin
          r_full[b] <= 1'b0;
        end
      end
      if (w_cap) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_rd_bank <= 1'b0;
      r_vec_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ch <= '0;
          if (r_full[r_rd_bank]) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_hs) begin
            if (r_ch != LAST_CH) begin
              r_ch <= r_ch + CH_W'(1);
            end else begin
              r_ch      <= '0;
              r_rd_bank <= ~r_rd_bank;
              r_vec_cnt <= (r_vec_cnt == LAST_VEC) ? '0 : r_vec_cnt + VC_W'(1);
              r_state   <= r_full[~r_rd_bank] ? STREAM : IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_valid      = w_stream;
  assign m_data       = w_stream ? (r_rd_bank ? w_bank_data[1] : w_bank_data[0]) : '0;
  assign m_ch_idx     = r_ch;
  assign m_last       = w_stream && (r_ch == LAST_CH);
  assign m_last_frame = m_last && (r_vec_cnt == LAST_VEC);
  assign overflow     = r_overflow;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_layer2_out_serializer.sv
// Self-checking bench: a queue-based reference model of the ping-pong serializer plus directed literal checks.
module tb_layer2_out_serializer;
  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 64;
  localparam int unsigned VPF = 4;
  localparam int unsigned DCW = 4;
  localparam int unsigned CW  = $clog2(NCH);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vin = 1'b0;
  logic [NCH*DW-1:0]  vdata = '0;
  logic               rdy = 1'b0;
  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [CW-1:0]      m_ch_idx;
  logic               m_last;
  logic               m_last_frame;
  logic               overflow;
  logic [DCW-1:0]     drop_cnt;

  always #5 clk = ~clk;

  layer2_out_serializer #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NCH),
    .VEC_PER_FRAME (VPF),
    .DROP_CNT_W    (DCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (vin),
    .data_in      (vdata),
    .m_valid      (m_valid),
    .m_ready      (rdy),
    .m_data       (m_data),
    .m_ch_idx     (m_ch_idx),
    .m_last       (m_last),
    .m_last_frame (m_last_frame),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // Reference model: buffered vectors in arrival order, at most two held at once.
  logic [NCH*DW-1:0] mq[$];
  bit          ms;
  int unsigned mch, mvc, mdrop;
  bit          movf;

  // Beats accepted by the DUT, as observed on the stream.
  logic [DW-1:0] obs_data[$];
  int unsigned   obs_ch[$];
  bit            obs_last[$];
  bit            obs_lf[$];
  int unsigned   obs_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NCH*DW-1:0] mkvec(input logic [DW-1:0] base);
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] rndvec();
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    ms = 0; mch = 0; mvc = 0; mdrop = 0; movf = 0;
  endfunction

  function automatic void model_step(input bit v_in, input logic [NCH*DW-1:0] vec, input bit ready);
    bit rel;
    int occ;
    bit acc;
    rel = ms && ready && (mch == NCH - 1);
    occ = int'(mq.size()) - (rel ? 1 : 0);
    acc = v_in && (occ < 2);
    if (v_in && !acc) begin
      movf = 1;
      if (mdrop < (1 << DCW) - 1) mdrop++;
    end
    if (ms) begin
      if (ready) begin
        if (mch < NCH - 1) mch++;
        else begin
          void'(mq.pop_front());
          mch = 0;
          mvc = (mvc + 1) % VPF;
          ms  = (mq.size() > 0);
        end
      end
    end else if (mq.size() > 0) begin
      ms = 1;
      mch = 0;
    end
    if (acc) mq.push_back(vec);
  endfunction

  task automatic check_model();
    logic [NCH*DW-1:0] v;
    bit lst;
    chk("m_valid", m_valid, ms);
    if (ms) begin
      v = mq[0];
      lst = (mch == NCH - 1);
      chk("m_data", m_data, v[mch*DW +: DW]);
      chk("m_ch_idx", m_ch_idx, mch);
      chk("m_last", m_last, lst);
      chk("m_last_frame", m_last_frame, lst && (mvc == VPF - 1));
    end else begin
      chk("m_last_idle", m_last, 0);
      chk("m_last_frame_idle", m_last_frame, 0);
    end
    chk("overflow", overflow, movf);
    chk("drop_cnt", drop_cnt, mdrop);
  endtask

  task automatic tick();
    bit hold;
    logic [DW-1:0] hd;
    logic [CW-1:0] hc;
    logic hl, hf;
    hold = m_valid && !rdy;
    hd = m_data; hc = m_ch_idx; hl = m_last; hf = m_last_frame;
    if (m_valid && rdy) begin
      obs_data.push_back(m_data);
      obs_ch.push_back(m_ch_idx);
      obs_last.push_back(m_last);
      obs_lf.push_back(m_last_frame);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step(vin, vdata, rdy);
    @(negedge clk);
    cyc++;
    check_model();
    if (hold) begin
      chk("stall_hold", {m_valid, m_data, m_ch_idx, m_last, m_last_frame},
          {1'b1, hd, hc, hl, hf});
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_ch.delete(); obs_last.delete(); obs_lf.delete(); obs_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vin = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_ch_idx", m_ch_idx, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_last_frame", m_last_frame, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    model_reset();
    clear_obs();
    rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string name, input int unsigned n, input int unsigned budget);
    int unsigned i = 0;
    while (obs_data.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk(name, obs_data.size(), n);
  endtask

  task automatic idle_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Mismatches of observed beats [first, first+NCH) against an incrementing-word vector.
  function automatic int unsigned seq_bad(input int unsigned first, input logic [DW-1:0] base);
    int unsigned bad = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (first + k >= obs_data.size()) bad++;
      else if (obs_data[first+k] !== base + DW'(k) || obs_ch[first+k] != k ||
               obs_last[first+k] != (k == NCH - 1)) bad++;
    end
    return bad;
  endfunction

  initial begin
    int unsigned bub, lfc, lfp;
    @(negedge clk);

    // 1: single vector, latency and ordering
    do_reset();
    rdy = 1'b1;
    vin = 1'b1; vdata = mkvec(32'h1000_0000);
    tick();
    vin = 1'b0;
    chk("t1_valid_after_capture", m_valid, 0);
    tick();
    chk("t1_valid_next_edge", m_valid, 1);
    chk("t1_first_data", m_data, 32'h1000_0000);
    run_until("t1_beats", 64, 200);
    idle_ticks(3);
    chk("t1_beat_count", obs_data.size(), 64);
    chk("t1_seq", seq_bad(0, 32'h1000_0000), 0);
    chk("t1_last_word", obs_data[63], 32'h1000_003F);
    chk("t1_valid_low_after", m_valid, 0);

    // 2: alternating backpressure
    do_reset();
    vin = 1'b1; vdata = mkvec(32'h1000_0000);
    rdy = 1'b1;
    tick();
    vin = 1'b0;
    for (int unsigned i = 0; i < 300 && obs_data.size() < 64; i++) begin
      rdy = ~rdy;
      tick();
    end
    rdy = 1'b1;
    idle_ticks(3);
    chk("t2_beat_count", obs_data.size(), 64);
    chk("t2_seq", seq_bad(0, 32'h1000_0000), 0);

    // 3: back-to-back vectors, no bubble
    do_reset();
    rdy = 1'b1;
    vin = 1'b1; vdata = mkvec(32'hA000_0000);
    tick();
    vdata = mkvec(32'hB000_0000);
    tick();
    vin = 1'b0;
    run_until("t3_beats", 128, 400);
    idle_ticks(3);
    bub = 0;
    for (int unsigned k = 1; k < obs_cyc.size(); k++)
      if (obs_cyc[k] != obs_cyc[k-1] + 1) bub++;
    chk("t3_bubbles", bub, 0);
    chk("t3_seqA", seq_bad(0, 32'hA000_0000), 0);
    chk("t3_seqB", seq_bad(64, 32'hB000_0000), 0);
    chk("t3_overflow", overflow, 0);

    // 4: overflow with downstream stalled
    do_reset();
    rdy = 1'b0;
    vin = 1'b1; vdata = mkvec(32'hA000_0000); tick();
    vdata = mkvec(32'hB000_0000); tick();
    vdata = mkvec(32'hC000_0000); tick();
    vin = 1'b0;
    tick();
    chk("t4_overflow", overflow, 1);
    chk("t4_drop_cnt", drop_cnt, 1);
    rdy = 1'b1;
    run_until("t4_beats", 128, 400);
    idle_ticks(10);
    chk("t4_beat_count", obs_data.size(), 128);
    chk("t4_seqA", seq_bad(0, 32'hA000_0000), 0);
    chk("t4_seqB", seq_bad(64, 32'hB000_0000), 0);

    // 5: frame marker with 4 vectors per frame, 5 vectors sent
    do_reset();
    rdy = 1'b1;
    for (int unsigned v = 0; v < 5; v++) begin
      vin = 1'b1; vdata = mkvec(32'h5000_0000 + DW'(v * 256));
      tick();
      vin = 1'b0;
      idle_ticks(70);
    end
    chk("t5_beat_count", obs_data.size(), 320);
    lfc = 0; lfp = 0;
    for (int unsigned k = 0; k < obs_lf.size(); k++)
      if (obs_lf[k]) begin lfc++; lfp = k; end
    chk("t5_lf_count", lfc, 1);
    chk("t5_lf_pos", lfp, 255);

    // 6: reset in the middle of a stream
    do_reset();
    rdy = 1'b0;
    vin = 1'b1; vdata = mkvec(32'h6000_0000); tick();
    vdata = mkvec(32'h6100_0000); tick();
    vdata = mkvec(32'h6200_0000); tick();
    vin = 1'b0;
    rdy = 1'b1;
    run_until("t6_to_beat20", 20, 100);
    chk("t6_overflow_pre", overflow, 1);
    chk("t6_valid_pre", m_valid, 1);
    do_reset();
    rdy = 1'b1;
    idle_ticks(100);
    chk("t6_no_beats", obs_data.size(), 0);
    vin = 1'b1; vdata = mkvec(32'h6300_0000); tick();
    vin = 1'b0;
    run_until("t6_new_beats", 64, 200);
    chk("t6_seq", seq_bad(0, 32'h6300_0000), 0);
    idle_ticks(3);

    // 7: drop counter saturation
    do_reset();
    rdy = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      vin = 1'b1; vdata = rndvec(); tick();
    end
    vin = 1'b0;
    tick();
    chk("t7_drop_sat", drop_cnt, 15);
    rdy = 1'b1;
    idle_ticks(140);

    // 8: randomized traffic
    do_reset();
    for (int unsigned i = 0; i < 4000; i++) begin
      vin = ($urandom_range(0, 99) < 3);
      vdata = rndvec();
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int unsigned i = 0; i < 600; i++) begin
      vin = ($urandom_range(0, 1) == 1);
      vdata = rndvec();
      rdy = ($urandom_range(0, 7) != 0);
      tick();
    end
    vin = 1'b0;
    rdy = 1'b1;
    idle_ticks(200);
    chk("t8_drained", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
